// File: rtl/clock_ctrl_pkg.sv
// Shared types and default constants for the slow-clock generator.
package clock_ctrl_pkg;

  // Controller states: free run, waiting for the high phase, frozen high, stepping low.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2,
    STEP_LOW  = 2'd3
  } clk_state_t;

  // Default half-period counter width and terminal counts for each freq setting.
  localparam int CNT_W_DEF = 26;
  localparam int DIV0_DEF  = 6250000;
  localparam int DIV1_DEF  = 25000000;
  localparam int DIV2_DEF  = 2500000;
  localparam int DIV3_DEF  = 1;

endpackage

// File: rtl/clock_ctrl_if.sv
// Control inputs and clock/strobe outputs of the slow-clock generator.
interface clock_ctrl_if;

  logic [1:0] freq;
  logic       halt;
  logic       step;
  logic       clk_out;
  logic       rise;
  logic       fall;
  logic       halted;

  // Requester side: drives divisor select and run control, observes the clock.
  modport master (
    output freq, halt, step,
    input  clk_out, rise, fall, halted
  );

  // Generator side.
  modport slave (
    input  freq, halt, step,
    output clk_out, rise, fall, halted
  );

endinterface

// File: rtl/clock_ctrl_half_period_counter.sv
// Half-period counter: counts up to a terminal value, then wraps to zero.
module half_period_counter
  import clock_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic             wrap
);

  logic [CNT_W-1:0] count;

  // Raw terminal-count flag; the controller decides whether it means a toggle.
  assign wrap = (count == term);

  // Clear has priority so a frozen clock always restarts its phase from zero.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// Programmable slow-clock generator with run/halt/single-step control.
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV0  = DIV0_DEF,
  parameter int DIV1  = DIV1_DEF,
  parameter int DIV2  = DIV2_DEF,
  parameter int DIV3  = DIV3_DEF
) (
  input  logic         clk,
  input  logic         reset,
  clock_ctrl_if.slave  bus
);

  clk_state_t       state;
  logic [CNT_W-1:0] div_act;
  logic             clk_out_r;
  logic             rise_r;
  logic             fall_r;
  logic             halted_r;
  logic             step_q;
  logic             step_rise;
  logic             wrap;
  logic             cnt_clr;

  function automatic logic [CNT_W-1:0] div_sel(input logic [1:0] f);
    case (f)
      2'b00:   return CNT_W'(DIV0);
      2'b01:   return CNT_W'(DIV1);
      2'b10:   return CNT_W'(DIV2);
      default: return CNT_W'(DIV3);
    endcase
  endfunction

  assign step_rise = bus.step & ~step_q;

  // Count is pinned at zero while frozen high, including the cycle a high-phase halt lands.
  assign cnt_clr = (state == HALTED) || ((state == RUN) && bus.halt && clk_out_r);

  half_period_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (~cnt_clr),
    .clr   (cnt_clr),
    .term  (div_act),
    .wrap  (wrap)
  );

  // Run/halt/step controller with registered clock, strobes and divisor latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      clk_out_r <= 1'b0;
      rise_r    <= 1'b0;
      fall_r    <= 1'b0;
      halted_r  <= 1'b0;
      step_q    <= 1'b0;
      div_act   <= div_sel(bus.freq);
    end else begin
      step_q <= bus.step;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      if (state == HALTED) begin
        div_act <= div_sel(bus.freq);
      end
      case (state)
        RUN: begin
          if (bus.halt && clk_out_r) begin
            state    <= HALTED;
            halted_r <= 1'b1;
          end else if (wrap) begin
            clk_out_r <= ~clk_out_r;
            rise_r    <= ~clk_out_r;
            fall_r    <= clk_out_r;
            div_act   <= div_sel(bus.freq);
            if (bus.halt) begin
              state    <= HALTED;
              halted_r <= 1'b1;
            end
          end else if (bus.halt) begin
            state <= HALT_PEND;
          end
        end
        HALT_PEND: begin
          if (wrap) begin
            clk_out_r <= 1'b1;
            rise_r    <= 1'b1;
            div_act   <= div_sel(bus.freq);
          end
          if (!bus.halt) begin
            state <= RUN;
          end else if (wrap) begin
            state    <= HALTED;
            halted_r <= 1'b1;
          end
        end
        HALTED: begin
          if (!bus.halt) begin
            state    <= RUN;
            halted_r <= 1'b0;
          end else if (step_rise) begin
            clk_out_r <= 1'b0;
            fall_r    <= 1'b1;
            state     <= STEP_LOW;
            halted_r  <= 1'b0;
          end
        end
        STEP_LOW: begin
          if (wrap) begin
            clk_out_r <= 1'b1;
            rise_r    <= 1'b1;
            div_act   <= div_sel(bus.freq);
            state     <= HALTED;
            halted_r  <= 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clk_out = clk_out_r;
  assign bus.rise    = rise_r;
  assign bus.fall    = fall_r;
  assign bus.halted  = halted_r;

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: stimulus queues expected edges, a monitor checks them.
module tb_clock_ctrl;

  typedef struct {
    bit is_rise;
    int at;
  } edge_t;

  logic   clk;
  logic   reset;
  int     cyc;
  int     n_tests;
  int     n_fail;
  int     c0;
  edge_t  exp_q[$];
  edge_t  mon_e;

  clock_ctrl_if bus();

  clock_ctrl #(
    .CNT_W (8),
    .DIV0  (3),
    .DIV1  (5),
    .DIV2  (2),
    .DIV3  (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    n_tests = 0;
    n_fail  = 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic push(input bit is_rise, input int at);
    edge_t e;
    e.is_rise = is_rise;
    e.at      = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_clk_out"}, 32'(bus.clk_out), 0);
    check({tag, "_halted"},  32'(bus.halted),  0);
    check({tag, "_rise"},    32'(bus.rise),    0);
    check({tag, "_fall"},    32'(bus.fall),    0);
  endtask

  // Monitor: every strobe must match the next queued edge in polarity and cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rise === 1'b1 || bus.fall === 1'b1) begin
        n_tests++;
        if (bus.rise === 1'b1 && bus.fall === 1'b1) begin
          n_fail++;
          $display("FAIL strobe_both at cyc %0d: got rise=1 fall=1, expected only one", cyc);
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_edge at cyc %0d: got rise=%0d fall=%0d, expected none",
                   cyc, bus.rise, bus.fall);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.is_rise != bus.rise || mon_e.at != cyc || bus.clk_out !== bus.rise) begin
            n_fail++;
            $display("FAIL edge_match: got rise=%0d clk_out=%0d at cyc %0d, expected rise=%0d at cyc %0d",
                     bus.rise, bus.clk_out, cyc, mon_e.is_rise, mon_e.at);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios with hand-computed edge times relative to c0.
  initial begin
    reset    = 1'b1;
    bus.freq = 2'b00;
    bus.halt = 1'b0;
    bus.step = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset0");
    c0    = cyc;
    reset = 1'b0;

    // Free run at DIV0=3: half-period of 4 cycles.
    push(1, c0 + 4);  push(0, c0 + 8);  push(1, c0 + 12); push(0, c0 + 16);
    wait_until(c0 + 3);  check("t1_low_4cyc", 32'(bus.clk_out), 0);
    wait_until(c0 + 4);  check("t1_first_rise", 32'(bus.clk_out), 1);

    // freq change mid-low: current low stays 4, then 6-cycle half-periods.
    push(1, c0 + 20); push(0, c0 + 26); push(1, c0 + 32); push(0, c0 + 38);
    wait_until(c0 + 17); bus.freq = 2'b01;
    wait_until(c0 + 25); check("t2_high_6cyc", 32'(bus.clk_out), 1);

    // Halt during low phase: low completes, halted rises with rise.
    push(1, c0 + 44);
    wait_until(c0 + 39); bus.halt = 1'b1;
    wait_until(c0 + 43); check("t3_pend_halted", 32'(bus.halted), 0);
    check("t3_pend_clk_out", 32'(bus.clk_out), 0);
    wait_until(c0 + 44); check("t3_halted_with_rise", 32'(bus.halted), 1);
    wait_until(c0 + 94); check("t3_stuck_high", 32'(bus.clk_out), 1);
    check("t3_still_halted", 32'(bus.halted), 1);
    bus.halt = 1'b0;
    push(0, c0 + 101); push(1, c0 + 107);
    wait_until(c0 + 95); check("t3_resume_halted", 32'(bus.halted), 0);
    // Halt while high: halted next cycle, no fall.
    wait_until(c0 + 108); bus.halt = 1'b1;
    wait_until(c0 + 109); check("t3_high_halt", 32'(bus.halted), 1);
    check("t3_high_clk_out", 32'(bus.clk_out), 1);

    // Single step at DIV0=3, step held 3 cycles, second pulse during STEP_LOW.
    bus.freq = 2'b00;
    push(0, c0 + 112); push(1, c0 + 116);
    wait_until(c0 + 111); bus.step = 1'b1;
    wait_until(c0 + 113); check("t4_step_low_halted", 32'(bus.halted), 0);
    wait_until(c0 + 114); bus.step = 1'b0;
    wait_until(c0 + 115); bus.step = 1'b1;
    wait_until(c0 + 116); bus.step = 1'b0;
    check("t4_back_halted", 32'(bus.halted), 1);
    wait_until(c0 + 120); check("t4_hold_high", 32'(bus.clk_out), 1);

    // DIV3=0: toggle every cycle; halt on a wrap cycle; halt drop beats step.
    bus.freq = 2'b11;
    bus.halt = 1'b0;
    push(0, c0 + 122); push(1, c0 + 123); push(0, c0 + 124); push(1, c0 + 125);
    wait_until(c0 + 125); bus.halt = 1'b1;
    wait_until(c0 + 126); check("t5_fast_halt", 32'(bus.halted), 1);
    check("t5_fast_clk_out", 32'(bus.clk_out), 1);
    wait_until(c0 + 128); bus.halt = 1'b0; bus.step = 1'b1;
    push(0, c0 + 130); push(1, c0 + 131); push(0, c0 + 132);
    wait_until(c0 + 129); bus.step = 1'b0;
    check("t5_run_not_step", 32'(bus.halted), 0);
    check("t5_run_clk_out", 32'(bus.clk_out), 1);

    // Halt on a low-phase wrap goes straight to HALTED; then reset mid-step.
    wait_until(c0 + 132); bus.halt = 1'b1; bus.freq = 2'b00;
    push(1, c0 + 133);
    wait_until(c0 + 133); check("t6_wrap_halt", 32'(bus.halted), 1);
    wait_until(c0 + 134); bus.step = 1'b1;
    push(0, c0 + 135);
    wait_until(c0 + 135); bus.step = 1'b0;
    wait_until(c0 + 136); reset = 1'b1;
    wait_until(c0 + 137); check_reset_state("t6_step_reset");
    reset = 1'b0; bus.halt = 1'b0;
    push(1, c0 + 141); push(0, c0 + 145);
    wait_until(c0 + 140); check("t6_low_after_reset", 32'(bus.clk_out), 0);

    // Reset during HALT_PEND.
    wait_until(c0 + 146); bus.halt = 1'b1;
    wait_until(c0 + 147); check("t6_pend_halted", 32'(bus.halted), 0);
    wait_until(c0 + 148); reset = 1'b1; bus.halt = 1'b0;
    wait_until(c0 + 149); check_reset_state("t6_pend_reset");
    reset = 1'b0;
    push(1, c0 + 153); push(0, c0 + 157);
    wait_until(c0 + 152); check("t6_pend_low", 32'(bus.clk_out), 0);
    wait_until(c0 + 160);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d, expected under %0d", cyc, 10000);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Programmable slow-clock generator for the MIPS core board build, driven from the board oscillator. It divides `clk` by a run-time-selectable divisor and adds a run/halt/single-step controller, so the processor clock can be frozen at a clean high level and advanced one period at a time. It also provides glitch-free frequency changes and one-cycle edge strobes for debug and display logic in the `clk` domain.

## Interface
- `CNT_W`, 26 — half-period counter width; every `DIVn` must be < 2^CNT_W.
- `DIV0`, 6250000 — half-period terminal count for `freq=2'b00`.
- `DIV1`, 25000000 — terminal count for `freq=2'b01`.
- `DIV2`, 2500000 — terminal count for `freq=2'b10`.
- `DIV3`, 1 — terminal count for `freq=2'b11`.

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- `clk`  in  1  board clock; all logic is clocked on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `freq`  in  2  divisor select.
- `halt`  in  1  level halt request.
- `step`  in  1  single-step request; rising-edge detected internally.
- `clk_out`  out  1  divided processor clock.
- `rise`  out  1  one-cycle strobe, asserted in the same cycle `clk_out` becomes 1.
- `fall`  out  1  one-cycle strobe, asserted in the same cycle `clk_out` becomes 0.
- `halted`  out  1  high while in state HALTED.

## Operation
- `div_act` is the active terminal count. It loads `DIV[freq]` at reset, at every `clk_out` toggle, and on every cycle spent in HALTED. It never changes mid-half-period.
- Wrap rule: if `count == div_act`, then `count <= 0` and a toggle occurs; otherwise `count <= count + 1`. Half-period = `div_act + 1` cycles; `div_act = 0` toggles every cycle.
- `step_rise = step & ~step_q`. `step_q` resets to 0.
- States:
  - RUN — free-running toggle.
    - `halt=1` with `clk_out=1`: go to HALTED immediately; no toggle that cycle, even on a wrap.
    - `halt=1` with `clk_out=0`: go to HALT_PEND; a wrap in that same cycle instead toggles to 1 and goes straight to HALTED.
  - HALT_PEND — keeps counting.
    - At wrap, `clk_out` becomes 1 and the state goes to HALTED.
    - `halt=0` returns to RUN without disturbing `count`.
  - HALTED — `clk_out` held at 1, `count` held at 0.
    - `halt=0` goes to RUN; the first toggle (to 0) occurs `div_act + 1` cycles later.
    - Otherwise `step_rise` makes `clk_out` 0 (`fall=1`), keeps `count` at 0, and goes to STEP_LOW.
  - STEP_LOW — counts the low phase. At wrap, `clk_out` becomes 1 (`rise=1`) and the state goes to HALTED. It always completes regardless of `halt`.
- `step_rise` is ignored outside HALTED. If `halt=0` and `step_rise` arrive together in HALTED, `halt=0` wins and the step is dropped.
- Reset values: state=RUN, `clk_out=0`, `count=0`, `rise=0`, `fall=0`, `halted=0`, `step_q=0`, `div_act=DIV[freq]`.
- Reset asserted mid-step or mid-halt aborts the operation; the state after reset is exactly the reset values.

## Timing
- All outputs are registered; none depends combinationally on an input.
- `halt` to `halted`:
  - 1 cycle if `clk_out=1`.
  - Otherwise the remaining low half-period, with `halted` rising in the same cycle as `rise`.
- A step yields exactly one `fall` and one `rise`, separated by `div_act + 1` cycles.
- `rise` and `fall` are never both high. Each is high for exactly one cycle per edge.
- A `freq` change takes effect from the half-period following the next toggle. The current half-period finishes at its old length.

## Structure
- Shared package `clock_ctrl_pkg`:
  - state enum `clk_state_t` (RUN, HALT_PEND, HALTED, STEP_LOW);
  - default divisor constants;
  - `CNT_W` default.
- One sub-module, `half_period_counter`: `CNT_W`-bit counter with inputs `en`, `clr` and `term`, and output `wrap`.
- The FSM, `div_act` mux and edge strobes live in `clock_ctrl`.

## Test plan
Use `DIV0=3`, `DIV1=5`, `DIV2=2` and `DIV3=0` unless noted.
1. Reset, `freq=00`, `halt=0` → `clk_out=0` for 4 cycles, then toggles every 4 cycles; a `rise`/`fall` strobe accompanies each edge.
2. Switch `freq` 00→01 mid-low-phase → the current low phase still lasts 4 cycles; subsequent half-periods last 6 cycles.
3. Assert `halt` one cycle after a `fall` → the low phase completes; `halted=1` together with `rise`; `clk_out` is stuck at 1 for 50 cycles. Assert `halt` while `clk_out=1` → `halted=1` the next cycle, with no `fall`.
4. In HALTED, pulse `step` for 3 cycles → exactly one `fall`, then `rise` 4 cycles later, then back in HALTED. A second `step` pulse during STEP_LOW is ignored.
5. `freq=11` (`DIV3=0`) → `clk_out` toggles every cycle. Assert `halt` → stop at high within 1 cycle. Drop `halt` together with a `step` edge → RUN with no step.
6. Assert `reset` during STEP_LOW and during HALT_PEND → the next cycle shows `clk_out=0`, `halted=0`, state RUN, and a first toggle after `DIV[freq]+1` cycles.
